cnn_mem_reader: RTL and testbench
=================================

Name: cnn_mem_reader

Overview:
- Read-side initiator for the CNN parameter/image RAM peripheral: sweeps a contiguous block of RAM words over the peripheral's chipselect/read/address bus.
- Buffers returned words in a small FIFO and presents them to the CNN datapath as a valid/ready stream with a last marker.
- Sits between the RAM peripheral (filled by the HPS) and the compute engine; flow control is credit-based, so backpressure never loses a word.

Parameters:
- DATA_W, 16, word width; matches RAM word and bus data width.
- ADDR_W, 16, RAM bus address width.
- LEN_W, 9, width of the transfer length; maximum 256 words.
- FIFO_DEPTH, 4, output buffer depth in words; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address; latched on an accepted start.
- length  in  LEN_W  word count; latched on an accepted start.
- m_chipselect  out  1  RAM bus select.
- m_read  out  1  RAM bus read strobe.
- m_address  out  ADDR_W  RAM bus address.
- m_readdata  in  DATA_W  RAM read data; valid exactly 1 cycle after the chipselect&read cycle.
- out_data  out  DATA_W  stream word (FIFO head).
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  marks the final word of the transfer.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at transfer completion.
- checksum  out  DATA_W  running checksum (see Optional Feature).

Behaviour:
- Reset values: m_chipselect=0, m_read=0, m_address=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, checksum=0. FIFO empty, counters 0, state IDLE.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on start=1, latch base_addr and length, set busy=1. Go to ISSUE if length>0; if length=0, go to DONE with no bus cycles.
  - ISSUE: one read per cycle when credits allow. After the last address is issued, go to DRAIN.
  - DRAIN: wait until the in-flight read has returned and the FIFO is empty, i.e. the last word has been accepted. Then go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- start outside IDLE: ignored.
- Credits: issue a read only if (FIFO occupancy + reads in flight) < FIFO_DEPTH. At most 1 read is in flight, given 1-cycle latency.
- Bus cycle:
  - m_chipselect and m_read are asserted together, registered outputs.
  - Read k drives m_address = base_addr + k, modulo 2^ADDR_W, so addresses wrap at 0xFFFF to 0x0000.
  - m_readdata is captured into the FIFO on the cycle after the strobe.
  - Reader never writes the RAM; no write strobe exists.
- Throughput: 1 word/cycle sustained while out_ready=1. First out_valid appears 2 cycles after the first strobe cycle.
- Stream: out_data/out_valid are held stable while out_valid=1 and out_ready=0. A word transfers on out_valid&out_ready.
- out_last=1 only with the word whose index is length-1. No word is dropped or duplicated under any out_ready pattern.
- Simultaneous FIFO push and pop at full or empty: both occur; occupancy unchanged.
- Reset mid-transfer: takes effect that clock edge. FSM to IDLE, FIFO flushed, an in-flight return is discarded, all outputs return to reset values.

Optional Feature:
- Macro: CNN_MEM_READER_CHECKSUM_EN.
- Defined:
  - checksum = 16-bit wrap-around sum of all words accepted on the stream in the current transfer.
  - Cleared to 0 on an accepted start.
  - Final value valid in the done cycle and held until the next start or reset.
- Undefined: checksum tied to 0; no adder logic.

Test Plan:
- RAM[0x10..0x13] = 0x0001, 0x0002, 0x0003, 0x0004; start with base 0x10, length 4, out_ready=1 -> strobes at 0x10..0x13 on consecutive cycles. Stream yields 1, 2, 3, 4 with out_last on 4; done pulses once; checksum = 0x000A when enabled.
- Same transfer with out_ready low for 5 cycles after the first word -> no more than FIFO_DEPTH words outstanding. out_data held stable while stalled; stream order 1, 2, 3, 4 intact.
- base 0xFFFE, length 3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- length 0 -> no m_chipselect cycle; busy high 1 cycle, then done pulse; no out_valid.
- start pulsed again mid-transfer -> ignored; original transfer completes unchanged.
- reset asserted during the 3rd word of a 256-word transfer -> next cycle all outputs at reset values. A new start then reads from its new base_addr correctly.

Source files
------------

// File: rtl/cnn_mem_reader.sv
// cnn_mem_reader: read-side initiator for the CNN parameter/image RAM.
// Sweeps base_addr .. base_addr+length-1 over a chipselect/read bus with
// one-cycle read latency. Returned words pass through a small FIFO and
// leave as a valid/ready stream that marks the final word with out_last.
// A read is issued only while (FIFO occupancy + reads in flight) is below
// FIFO_DEPTH, so stalling the stream never loses a word.
// Optional feature macro: CNN_MEM_READER_CHECKSUM_EN. When it is defined,
// checksum is a 16-bit wrap-around sum of the words accepted on the stream.
// Stream handshake: a word moves when out_valid && out_ready are both high
// on a rising edge. While out_valid=1 and out_ready=0, out_data and
// out_last hold their values.
// dbg_state exposes the FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE).
module cnn_mem_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              m_chipselect,
  output logic              m_read,
  output logic [ADDR_W-1:0] m_address,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;           // next address to issue
  logic [LEN_W-1:0]  left_q, left_d;           // reads still to issue
  logic              strobe_q, strobe_d;       // bus strobe this cycle
  logic              strobe_last_q, strobe_last_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic              pend_q;                   // read data returning this cycle
  logic              pend_last_q;
  logic              done_q;
  logic              accept;

  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic              last_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop, issue_ok;
  logic [OCC_W-1:0]  occ;

  assign push = pend_q;
  assign pop  = out_valid & out_ready;

  // Words that will be buffered or in flight after this edge, before a new issue.
  assign occ = OCC_W'(count_q) + OCC_W'(pend_q) + OCC_W'(strobe_q) - OCC_W'(pop);
  assign issue_ok = (occ < OCC_W'(FIFO_DEPTH));

  assign m_chipselect = strobe_q;
  assign m_read       = strobe_q;
  assign m_address    = m_address_q;
  assign out_valid    = (count_q != '0);
  assign out_data     = data_mem_q[rd_ptr_q];
  assign out_last     = out_valid & last_mem_q[rd_ptr_q];
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign dbg_state    = state_q;

  // Next-state, issue and address generation.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    left_d        = left_q;
    strobe_d      = 1'b0;
    strobe_last_d = 1'b0;
    m_address_d   = m_address_q;
    accept        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          addr_d  = base_addr;
          left_d  = length;
          state_d = (length == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ok) begin
          strobe_d      = 1'b1;
          m_address_d   = addr_q;
          addr_d        = addr_q + ADDR_W'(1);
          left_d        = left_q - LEN_W'(1);
          strobe_last_d = (left_q == LEN_W'(1));
          if (left_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!strobe_q && !pend_q && (count_q == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy update.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM, bus and return-pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      left_q        <= '0;
      strobe_q      <= 1'b0;
      strobe_last_q <= 1'b0;
      m_address_q   <= '0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      left_q        <= left_d;
      strobe_q      <= strobe_d;
      strobe_last_q <= strobe_last_d;
      m_address_q   <= m_address_d;
      pend_q        <= strobe_q;
      pend_last_q   <= strobe_last_q;
      done_q        <= (state_q == S_DONE);
    end
  end

  // Output FIFO: capture returning read data, advance head on stream accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        last_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= m_readdata;
        last_mem_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

`ifdef CNN_MEM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running sum of accepted stream words, cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + out_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cnn_mem_reader.sv
// Testbench for cnn_mem_reader: RAM model, directed transfers, scoreboard.
module tb_cnn_mem_reader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 9;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              m_chipselect, m_read;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_ready, out_last;
  logic              busy, done;
  logic [DATA_W-1:0] checksum;
  logic [1:0]        dbg_state;

  cnn_mem_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .m_chipselect(m_chipselect), .m_read(m_read),
    .m_address(m_address), .m_readdata(m_readdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // RAM model: word at address a is a - 0x000F; data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (m_chipselect && m_read) m_readdata <= m_address - 16'h000F;
    else                        m_readdata <= 16'hDEAD;
  end

  // Scoreboard state
  logic [DATA_W:0]   exp_q[$];       // {last, data}
  logic [ADDR_W-1:0] exp_addr_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, n_strobe = 0, n_accept = 0, done_cnt = 0, busy_cyc = 0, valid_seen = 0;
  int first_strobe = -1, last_strobe = -1, first_valid = -1, max_outst = 0;
  logic [DATA_W-1:0] done_sum = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DATA_W-1:0] exp_sum(input logic [DATA_W-1:0] v);
`ifdef CNN_MEM_READER_CHECKSUM_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  // Monitor: bus strobes, stream words, done pulses.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (m_chipselect) begin
        n_strobe++;
        if (first_strobe < 0) first_strobe = cyc;
        last_strobe = cyc;
        check("strobe_read", m_read, 1);
        if (exp_addr_q.size() == 0) check("addr_unexpected", m_address, 32'hFFFF_FFFF);
        else check("addr", m_address, exp_addr_q.pop_front());
      end
      if (n_strobe - n_accept > max_outst) max_outst = n_strobe - n_accept;
      if (out_valid) begin
        valid_seen++;
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          check("word_unexpected", out_data, 32'hFFFF_FFFF);
        end else begin
          check("data", out_data, exp_q[0][DATA_W-1:0]);
          check("last", out_last, exp_q[0][DATA_W]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_accept++;
          end
        end
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_sum = checksum;
        check("busy_in_done", busy, 0);
      end
    end
  end

  // Driver tasks
  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    first_strobe = -1; first_valid = -1;
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_words(input logic [ADDR_W-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      logic [ADDR_W-1:0] a;
      a = b + ADDR_W'(k);
      exp_addr_q.push_back(a);
      exp_q.push_back({(k == n - 1), a - 16'h000F});
    end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 2000) begin
      @(posedge clk); t++;
    end
    check("done_seen", (done_cnt >= target), 1);
    repeat (3) @(posedge clk);
    check("done_count", done_cnt, target);
    check("queue_drained", exp_q.size(), 0);
    check("addr_drained", exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cs", m_chipselect, 0);
    check("rst_rd", m_read, 0);
    check("rst_addr", m_address, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", checksum, 0);
  endtask

  initial begin
    int s0, a0, b0, v0, d0, t;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1; reset = 1'b0;

    // 1: base 0x10, length 4, free-running consumer
    push_words(16'h0010, 4);
    s0 = n_strobe; d0 = 1;
    do_start(16'h0010, 9'd4);
    wait_done(d0);
    check("t1_strobes", n_strobe - s0, 4);
    check("t1_consecutive", last_strobe - first_strobe, 3);
    check("t1_first_valid_lat", first_valid - first_strobe, 2);
    check("t1_sum", done_sum, exp_sum(16'h000A));

    // 2: stall consumer for 5 cycles after the first word
    push_words(16'h0010, 4);
    a0 = n_accept;
    do_start(16'h0010, 9'd4);
    t = 0;
    while (n_accept < a0 + 1 && t < 100) begin @(posedge clk); #1; t++; end
    check("t2_first_word", (n_accept >= a0 + 1), 1);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(2);
    check("t2_sum", done_sum, exp_sum(16'h000A));

    // 2b: consumer stalled from the start; credits limit reads to FIFO depth
    push_words(16'h0010, 8);
    max_outst = 0; s0 = n_strobe;
    out_ready = 1'b0;
    do_start(16'h0010, 9'd8);
    repeat (12) @(posedge clk);
    check("t2b_strobes_stalled", n_strobe - s0, DEPTH);
    #1 out_ready = 1'b1;
    wait_done(3);
    check("t2b_max_outstanding", max_outst, DEPTH);
    check("t2b_sum", done_sum, exp_sum(16'h0024));

    // 3: address wrap 0xFFFE, 0xFFFF, 0x0000
    push_words(16'hFFFE, 3);
    do_start(16'hFFFE, 9'd3);
    wait_done(4);
    check("t3_sum", done_sum, exp_sum(16'hFFD0));

    // 4: length 0
    s0 = n_strobe; b0 = busy_cyc; v0 = valid_seen;
    do_start(16'h0050, 9'd0);
    wait_done(5);
    check("t4_no_strobe", n_strobe - s0, 0);
    check("t4_busy_cycles", busy_cyc - b0, 1);
    check("t4_no_valid", valid_seen - v0, 0);
    check("t4_sum", done_sum, 0);

    // 5: second start mid-transfer is ignored
    push_words(16'h0010, 4);
    s0 = n_strobe;
    do_start(16'h0010, 9'd4);
    repeat (2) @(posedge clk);
    #1 base_addr = 16'h0040; length = 9'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(6);
    check("t5_strobes", n_strobe - s0, 4);
    check("t5_sum", done_sum, exp_sum(16'h000A));

    // 6: reset during the third word of a 256-word transfer
    push_words(16'h0100, 256);
    a0 = n_accept;
    do_start(16'h0100, 9'd256);
    t = 0;
    while (n_accept < a0 + 2 && t < 100) begin @(posedge clk); #1; t++; end
    check("t6_two_words", (n_accept >= a0 + 2), 1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    push_words(16'h0020, 2);
    do_start(16'h0020, 9'd2);
    wait_done(7);
    check("t6_sum", done_sum, exp_sum(16'h0023));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
